// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : uart_tx_fifo
// Brief   : UART transmitter with a power-of-two transmit FIFO and
//           configurable data width, parity mode and stop bits.
// Revision: 1.0
// ----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          TxD,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0]  FULL      = CNT_W'(FIFO_DEPTH);
  localparam logic              ODD_FLIP  = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     fifo_count_q, fifo_count_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;

  logic                 push;
  logic                 pop;
  logic                 have_word;
  logic                 bit_end;
  logic [DATA_BITS-1:0] head;

  assign tx_ready   = (fifo_count_q != FULL);
  assign TxD        = txd_q;
  assign busy       = busy_q;
  assign fifo_count = fifo_count_q;

  assign push      = tx_valid && tx_ready;
  assign have_word = (fifo_count_q != '0);
  assign bit_end   = (state_q != S_IDLE) && (baud_q == BAUD_LAST);
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    txd_d        = txd_q;
    busy_d       = busy_q;
    pop          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (have_word) pop = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          txd_d     = shift_q[0];
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
              txd_d   = par_q;
            end else begin
              state_d = S_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d   = S_STOP;
          txd_d     = 1'b1;
          bit_cnt_d = '0;
        end
      end
      S_STOP: begin
        // bit_cnt_q counts stop bits so each one is a full baud period
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            if (have_word) begin
              pop = 1'b1;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Loading a word is shared by IDLE and the back-to-back path out of STOP
    if (pop) begin
      state_d   = S_START;
      txd_d     = 1'b0;
      busy_d    = 1'b1;
      shift_d   = head;
      par_d     = (^head) ^ ODD_FLIP;
      bit_cnt_d = '0;
      rd_ptr_d  = rd_ptr_q + 1'b1;
    end

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + 1'b1;
      2'b01:   fifo_count_d = fifo_count_q - 1'b1;
      default: fifo_count_d = fifo_count_q;
    endcase

    baud_d = (state_q == S_IDLE || bit_end) ? '0 : baud_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      baud_q       <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      txd_q        <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      baud_q       <= baud_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      txd_q        <= txd_d;
      busy_q       <= busy_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_uart_tx_fifo
// Brief   : Self-checking bench for uart_tx_fifo against a queue-based
//           serial-line model, plus hand-written frame tables.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int CPB = 4;
  localparam int DB  = 8;
  localparam int PAR = 2;
  localparam int SB  = 1;
  localparam int FD  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       txd;
  logic       busy;
  logic [2:0] fifo_count;

  logic [6:0] b_data;
  logic       b_valid;
  logic       b_ready;
  logic       b_txd;
  logic       b_busy;
  logic [2:0] b_count;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(PAR), .STOP_BITS(SB), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .TxD(txd), .busy(busy), .fifo_count(fifo_count)
  );

  uart_tx_fifo #(
    .CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .reset(reset), .tx_data(b_data), .tx_valid(b_valid),
    .tx_ready(b_ready), .TxD(b_txd), .busy(b_busy), .fifo_count(b_count)
  );

  int checks = 0;
  int fails  = 0;

  // Reference model: words waiting in the FIFO, and the per-cycle line values
  // still to be shifted out for the frame in flight.
  logic [7:0] mq[$];
  bit         line[$];

  typedef struct {
    logic [7:0]  data;
    logic [10:0] bits;  // bit 0 = start ... bit 10 = stop
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
    end
  endtask

  task automatic build_frame(input logic [7:0] w);
    int ones;
    bit b[$];
    ones = 0;
    b.push_back(1'b0);
    for (int i = 0; i < DB; i++) begin
      b.push_back(w[i]);
      ones += int'(w[i]);
    end
    b.push_back((ones % 2) == 1);  // even parity: total ones come out even
    for (int s = 0; s < SB; s++) b.push_back(1'b1);
    foreach (b[k]) repeat (CPB) line.push_back(b[k]);
  endtask

  task automatic step(input bit v, input logic [7:0] d, output bit acc);
    bit m_ready;
    bit e_txd;
    bit e_busy;
    logic [7:0] w;
    @(negedge clk);
    tx_valid = v;
    tx_data  = d;
    @(posedge clk);
    m_ready = (mq.size() != FD);
    if (line.size() > 0) begin
      e_txd = line.pop_front(); e_busy = 1'b1;
    end else if (mq.size() > 0) begin
      w = mq.pop_front();
      build_frame(w);
      e_txd = line.pop_front(); e_busy = 1'b1;
    end else begin
      e_txd = 1'b1; e_busy = 1'b0;
    end
    acc = v && m_ready;
    if (acc) mq.push_back(d);
    #1;
    chk("txd", 32'(txd), 32'(e_txd));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("tx_ready", 32'(tx_ready), 32'(mq.size() != FD));
  endtask

  task automatic drain();
    bit acc;
    for (int k = 0; k < 2000 && (mq.size() > 0 || line.size() > 0); k++) step(1'b0, 8'h00, acc);
    step(1'b0, 8'h00, acc);
    chk("drain_idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    bit saw_full;
    logic [10:0] bexp;
    int i;

    vecs[0] = '{8'hA5, 11'b1_0_10100101_0};
    vecs[1] = '{8'h00, 11'b1_0_00000000_0};
    vecs[2] = '{8'hFF, 11'b1_0_11111111_0};
    vecs[3] = '{8'h01, 11'b1_1_00000001_0};
    vecs[4] = '{8'h80, 11'b1_1_10000000_0};
    vecs[5] = '{8'h3C, 11'b1_0_00111100_0};

    reset = 1'b0; tx_valid = 1'b0; tx_data = '0; b_valid = 1'b0; b_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_count", 32'(fifo_count), 32'd0);
    @(negedge clk) reset = 1'b1;
    repeat (3) step(1'b0, 8'h00, acc);

    // Hand-computed frames, each sent into an empty, idle transmitter
    for (int v = 0; v < 6; v++) begin
      step(1'b1, vecs[v].data, acc);
      chk("vec_accept", 32'(acc), 32'd1);
      for (int c = 0; c < 44; c++) begin
        step(1'b0, 8'h00, acc);
        chk("vec_bit", 32'(txd), 32'(vecs[v].bits[c / CPB]));
        chk("vec_busy", 32'(busy), 32'd1);
      end
      step(1'b0, 8'h00, acc);
      chk("vec_end_busy", 32'(busy), 32'd0);
      chk("vec_end_txd", 32'(txd), 32'd1);
    end

    // Burst with tx_valid held high: fills, stalls, back-to-back frames
    saw_full = 1'b0;
    i = 1;
    for (int k = 0; k < 1000 && i <= 6; k++) begin
      step(1'b1, 8'(i), acc);
      if (fifo_count == 3'd4 && tx_ready == 1'b0) saw_full = 1'b1;
      if (acc) i++;
    end
    chk("burst_all_accepted", 32'(i), 32'd7);
    chk("burst_full_seen", 32'(saw_full), 32'd1);
    drain();

    // Reset mid-frame during data bit 3 with two words queued
    step(1'b1, 8'h3C, acc);
    step(1'b1, 8'h11, acc);
    step(1'b1, 8'h22, acc);
    repeat (16) step(1'b0, 8'h00, acc);
    chk("pre_rst_count", 32'(fifo_count), 32'd2);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_txd", 32'(txd), 32'd1);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_count", 32'(fifo_count), 32'd0);
    chk("async_rst_ready", 32'(tx_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    mq.delete();
    line.delete();
    repeat (100) step(1'b0, 8'h00, acc);

    // Second instance: 7 data bits, odd parity, two stop bits
    bexp = 11'b111_0000000_0;
    @(negedge clk); b_data = 7'h00; b_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); b_valid = 1'b0;
    for (int c = 0; c < 44; c++) begin
      if (c > 0) @(posedge clk);
      else @(posedge clk);
      #1;
      chk("b_bit", 32'(b_txd), 32'(bexp[c / 4]));
      chk("b_busy", 32'(b_busy), 32'd1);
    end
    @(posedge clk); #1;
    chk("b_end_busy", 32'(b_busy), 32'd0);
    chk("b_end_txd", 32'(b_txd), 32'd1);

    // Random traffic: sparse then dense
    for (int k = 0; k < 1500; k++) step($urandom_range(0, 29) == 0, 8'($urandom), acc);
    for (int k = 0; k < 500; k++) step($urandom_range(0, 1) == 1, 8'($urandom), acc);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
